// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM state encoding,
// special scan-code bytes and the odd-parity helper.
`timescale 1ns/1ps
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    DONE
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_NONE = 8'h00;

  // A PS/2 frame is good when the data byte plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] i_byte, input logic i_par);
    return ^{i_byte, i_par};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// PS/2 line conditioning: two-flop synchronisers on clock and data, a
// FILTER_LEN-sample glitch filter on the clock, and a one-cycle strobe on each
// filtered falling edge (the moment the device guarantees data is stable).
`timescale 1ns/1ps
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_data_sync,
  output logic o_clk_fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    r_clk_ff;
  logic [1:0]    r_data_ff;
  logic          r_clk_filt;
  logic [CW-1:0] r_cnt;
  logic          r_fall;
  logic          w_clk_s;

  assign w_clk_s     = r_clk_ff[1];
  assign o_data_sync = r_data_ff[1];
  assign o_clk_fall  = r_fall;

  // Bring both open-collector lines into the clock domain; idle bus level is high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_ff  <= 2'b11;
      r_data_ff <= 2'b11;
    end else begin
      r_clk_ff  <= {r_clk_ff[0], i_ps2_clk};
      r_data_ff <= {r_data_ff[0], i_ps2_data};
    end
  end

  // Accept a new clock level only after FILTER_LEN consecutive disagreeing samples; flag 1->0 flips.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_filt <= 1'b1;
      r_cnt      <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (w_clk_s == r_clk_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_clk_filt <= w_clk_s;
        r_cnt      <= '0;
        r_fall     <= ~w_clk_s;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver feeding the keyboard port of the memory controller.
// Deserialises device-to-host frames, swallows E0/F0 prefixes and presents the
// make code of the currently held key on o_scan_code.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity;
// otherwise the parity bit is consumed and only the stop bit is checked.
`timescale 1ns/1ps
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = CLK_HZ / 1000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_scan_code,
  output logic       o_key_valid,
  output logic       o_key_held,
  output logic       o_frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYC - 1);

  ps2_state_e    r_state;
  ps2_state_e    w_next;
  logic          w_data_sync;
  logic          w_clk_fall;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic [TW-1:0] r_tcnt;
  logic          r_brk;
  logic [7:0]    r_scan;
  logic          r_held;
  logic          r_valid;
  logic          r_err;
  logic          w_busy;
  logic          w_timeout;
  logic          w_stop_ok;
  logic          w_start;
  logic          w_shift;
  logic          w_start_err;
  logic          w_stop_err;
  logic          w_decode;
`ifdef PS2_PARITY_CHECK_EN
  logic          r_parity;
  logic          w_cap_par;
`endif

  ps2_sync_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync_filter (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_ps2_clk   (i_ps2_clk),
    .i_ps2_data  (i_ps2_data),
    .o_data_sync (w_data_sync),
    .o_clk_fall  (w_clk_fall)
  );

  assign w_busy    = (r_state == DATA) || (r_state == PARITY) || (r_state == STOP);
  assign w_timeout = w_busy && !w_clk_fall && (r_tcnt == TOUT_LAST);

`ifdef PS2_PARITY_CHECK_EN
  assign w_stop_ok = w_data_sync && odd_parity_ok(r_shift, r_parity);
`else
  assign w_stop_ok = w_data_sync;
`endif

  assign o_scan_code   = r_scan;
  assign o_key_valid   = r_valid;
  assign o_key_held    = r_held;
  assign o_frame_error = r_err;

  // Frame state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Frame progression moves on sample strobes; a stalled frame is abandoned on timeout.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_clk_fall && !w_data_sync) w_next = DATA;
      DATA:    if (w_clk_fall) begin
                 if (r_bit_cnt == 3'd7) w_next = PARITY;
               end else if (w_timeout) w_next = IDLE;
      PARITY:  if (w_clk_fall) w_next = STOP;
               else if (w_timeout) w_next = IDLE;
      STOP:    if (w_clk_fall) w_next = w_stop_ok ? DONE : IDLE;
               else if (w_timeout) w_next = IDLE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Per-state datapath strobes derived from the current state and the sample strobe.
  always_comb begin
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_start_err = 1'b0;
    w_stop_err  = 1'b0;
    w_decode    = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    w_cap_par   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_start     = w_clk_fall & ~w_data_sync;
        w_start_err = w_clk_fall &  w_data_sync;
      end
      DATA:   w_shift    = w_clk_fall;
`ifdef PS2_PARITY_CHECK_EN
      PARITY: w_cap_par  = w_clk_fall;
`endif
      STOP:   w_stop_err = w_clk_fall & ~w_stop_ok;
      DONE:   w_decode   = 1'b1;
      default: ;
    endcase
  end

  // Shift data bits in LSB first and count them; the count restarts on every start bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_start) begin
      r_bit_cnt <= '0;
    end else if (w_shift) begin
      r_shift   <= {w_data_sync, r_shift[7:1]};
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  // Hold the received parity bit for the check made when the stop bit arrives.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_parity <= 1'b0;
    else if (w_cap_par) r_parity <= w_data_sync;
  end
`endif

  // Count idle cycles inside a frame; any strobe restarts the count, so a coincident strobe beats the timeout.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                    r_tcnt <= '0;
    else if (!w_busy || w_clk_fall)  r_tcnt <= '0;
    else if (!w_timeout)             r_tcnt <= r_tcnt + TW'(1);
  end

  // Decode completed bytes into held-key tracking; prefixes only arm the break flag (E0 is just swallowed).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_brk   <= 1'b0;
      r_scan  <= PS2_NONE;
      r_held  <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= w_start_err | w_stop_err | w_timeout;
      if (w_stop_err) r_brk <= 1'b0;
      if (w_decode) begin
        if (r_shift == PS2_BRK) begin
          r_brk <= 1'b1;
        end else if (r_shift != PS2_EXT) begin
          r_brk <= 1'b0;
          if (!r_brk) begin
            r_scan  <= r_shift;
            r_held  <= 1'b1;
            r_valid <= 1'b1;
          end else if (r_shift == r_scan) begin
            r_scan <= PS2_NONE;
            r_held <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: a table of key sequences with fixed
// expectations, hand-written timeout / glitch / reset sequences, then random
// frames checked against a byte-level keyboard model.
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 300;
  localparam int HP          = 20;
  localparam int LATENCY     = 2 + FILTER_LEN + 2;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_CHECK = 1'b1;
`else
  localparam bit PAR_CHECK = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    bit         flipPar;
    bit         badStop;
    logic [7:0] expScan;
    bit         expHeld;
    int         expValid;
    int         expErr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstN = 1'b1;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic [7:0] scanCode;
  logic       keyValid;
  logic       keyHeld;
  logic       frameError;

  int checks = 0;
  int errors = 0;
  int nValid = 0;
  int nErr = 0;
  int cyc = 0;
  int stopCyc = 0;
  int lastValidCyc = 0;

  logic [7:0] mScan = 8'h00;
  bit         mHeld = 1'b0;
  bit         mBrk = 1'b0;
  bit         mExt = 1'b0;
  int         mValid = 0;
  int         mErr = 0;

  vec_t vecs[16];

  ps2_keyboard_rx #(
    .CLK_HZ      (50_000_000),
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_ps2_clk     (ps2Clk),
    .i_ps2_data    (ps2Data),
    .o_scan_code   (scanCode),
    .o_key_valid   (keyValid),
    .o_key_held    (keyHeld),
    .o_frame_error (frameError)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Count output pulses away from the active edge.
  always @(negedge clk) begin
    if (keyValid === 1'b1) begin
      nValid = nValid + 1;
      lastValidCyc = cyc;
    end
    if (frameError === 1'b1) nErr = nErr + 1;
  end

  // Hard stop in case something never returns.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Keyboard behaviour at byte level: prefixes arm flags, other bytes press or release.
  task automatic modelFrame(input logic [7:0] b, input bit parOk, input bit stopOk);
    if (!stopOk || (PAR_CHECK && !parOk)) begin
      mErr = mErr + 1;
      mBrk = 1'b0;
      mExt = 1'b0;
    end else if (b == 8'hE0) begin
      mExt = 1'b1;
    end else if (b == 8'hF0) begin
      mBrk = 1'b1;
    end else begin
      if (!mBrk) begin
        mScan  = b;
        mHeld  = 1'b1;
        mValid = mValid + 1;
      end else if (b == mScan) begin
        mScan = 8'h00;
        mHeld = 1'b0;
      end
      mBrk = 1'b0;
      mExt = 1'b0;
    end
  endtask

  // One PS/2 bit cell: data set while clock high, then a low phase; optional short clock glitch.
  task automatic ps2Bit(input logic d, input bit glitch, input bit markStop);
    ps2Data = d;
    if (glitch) begin
      repeat (8) @(negedge clk);
      ps2Clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2Clk = 1'b1;
      repeat (HP - 11) @(negedge clk);
    end else begin
      repeat (HP) @(negedge clk);
    end
    ps2Clk = 1'b0;
    if (markStop) stopCyc = cyc;
    repeat (HP) @(negedge clk);
    ps2Clk = 1'b1;
  endtask

  // Send a full 11-bit frame and advance the model.
  task automatic applyStimulus(input logic [7:0] b, input bit flipPar, input bit badStop, input int glitchBit);
    logic [10:0] bits;
    logic        p;
    p = ~(^b);
    if (flipPar) p = ~p;
    bits = {~badStop, p, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2Bit(bits[i], (i == glitchBit), (i == 10));
    ps2Data = 1'b1;
    repeat (HP + 30) @(negedge clk);
    modelFrame(b, !flipPar, !badStop);
  endtask

  // Start bit plus a few data bits, then silence long enough to trip the timeout.
  task automatic sendPartial(input int nBits);
    ps2Bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nBits; i++) ps2Bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    ps2Data = 1'b1;
    repeat (TIMEOUT_CYC + 100) @(negedge clk);
    mErr = mErr + 1;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_scan"}, scanCode, mScan);
    checkOutput({tag, "_held"}, keyHeld, mHeld);
    checkOutput({tag, "_valid_cnt"}, nValid, mValid);
    checkOutput({tag, "_err_cnt"}, nErr, mErr);
  endtask

  initial begin
    int vBefore;
    int eBefore;
    logic [7:0] after12;
    logic [7:0] b;
    int r;

`ifdef PS2_PARITY_CHECK_EN
    after12 = 8'h1D;
`else
    after12 = 8'h1B;
`endif
    vecs[0]  = '{8'h1C, 1'b0, 1'b0, 8'h1C, 1'b1, 1, 0};
    vecs[1]  = '{8'hF0, 1'b0, 1'b0, 8'h1C, 1'b1, 0, 0};
    vecs[2]  = '{8'h1C, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0};
    vecs[3]  = '{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0};
    vecs[4]  = '{8'h75, 1'b0, 1'b0, 8'h75, 1'b1, 1, 0};
    vecs[5]  = '{8'hE0, 1'b0, 1'b0, 8'h75, 1'b1, 0, 0};
    vecs[6]  = '{8'hF0, 1'b0, 1'b0, 8'h75, 1'b1, 0, 0};
    vecs[7]  = '{8'h75, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0};
    vecs[8]  = '{8'h1D, 1'b0, 1'b0, 8'h1D, 1'b1, 1, 0};
    vecs[9]  = '{8'hF0, 1'b0, 1'b0, 8'h1D, 1'b1, 0, 0};
    vecs[10] = '{8'h1B, 1'b0, 1'b0, 8'h1D, 1'b1, 0, 0};
    vecs[11] = '{8'h1D, 1'b0, 1'b0, 8'h1D, 1'b1, 1, 0};
`ifdef PS2_PARITY_CHECK_EN
    vecs[12] = '{8'h1B, 1'b1, 1'b0, 8'h1D, 1'b1, 0, 1};
`else
    vecs[12] = '{8'h1B, 1'b1, 1'b0, 8'h1B, 1'b1, 1, 0};
`endif
    vecs[13] = '{8'hF0, 1'b0, 1'b0, after12, 1'b1, 0, 0};
    vecs[14] = '{8'h22, 1'b0, 1'b1, after12, 1'b1, 0, 1};
    vecs[15] = '{8'h22, 1'b0, 1'b0, 8'h22, 1'b1, 1, 0};

    #1 rstN = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("reset_scan", scanCode, 8'h00);
    checkOutput("reset_held", keyHeld, 1'b0);
    checkOutput("reset_valid", keyValid, 1'b0);
    checkOutput("reset_err", frameError, 1'b0);
    rstN = 1'b1;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      vBefore = nValid;
      eBefore = nErr;
      applyStimulus(vecs[i].data, vecs[i].flipPar, vecs[i].badStop, -1);
      checkOutput($sformatf("vec%0d_scan", i), scanCode, vecs[i].expScan);
      checkOutput($sformatf("vec%0d_held", i), keyHeld, vecs[i].expHeld);
      checkOutput($sformatf("vec%0d_valid", i), nValid - vBefore, vecs[i].expValid);
      checkOutput($sformatf("vec%0d_err", i), nErr - eBefore, vecs[i].expErr);
      if (i == 0) checkOutput("latency", lastValidCyc - stopCyc, LATENCY);
    end
    checkModel("table_end");

    $display("[TB] timeout sequences");
    sendPartial(4);
    checkModel("timeout1");
    applyStimulus(8'h23, 1'b0, 1'b0, -1);
    checkOutput("after_timeout_scan", scanCode, 8'h23);
    checkModel("after_timeout");
    applyStimulus(8'hF0, 1'b0, 1'b0, -1);
    sendPartial(4);
    applyStimulus(8'h23, 1'b0, 1'b0, -1);
    checkOutput("brk_kept_scan", scanCode, 8'h00);
    checkOutput("brk_kept_held", keyHeld, 1'b0);
    checkModel("brk_kept");

    $display("[TB] glitch sequence");
    vBefore = nValid;
    applyStimulus(8'h5A, 1'b0, 1'b0, 3);
    checkOutput("glitch_scan", scanCode, 8'h5A);
    checkOutput("glitch_valid", nValid - vBefore, 1);
    checkModel("glitch");

    $display("[TB] stray edge with data high");
    ps2Bit(1'b1, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    mErr = mErr + 1;
    checkModel("stray");

    $display("[TB] reset mid-frame");
    ps2Bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ps2Bit(1'b1, 1'b0, 1'b0);
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midreset_scan", scanCode, 8'h00);
    checkOutput("midreset_held", keyHeld, 1'b0);
    rstN = 1'b1;
    mScan = 8'h00;
    mHeld = 1'b0;
    mBrk  = 1'b0;
    mExt  = 1'b0;
    ps2Data = 1'b1;
    repeat (20) @(negedge clk);
    applyStimulus(8'h23, 1'b0, 1'b0, -1);
    checkOutput("after_reset_scan", scanCode, 8'h23);
    checkModel("after_reset");

    $display("[TB] random frames");
    for (int n = 0; n < 30; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2)                        b = 8'hF0;
      else if (r == 2)                  b = 8'hE0;
      else if (r < 5 && mScan != 8'h0)  b = mScan;
      else                              b = 8'($urandom);
      applyStimulus(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0), -1);
      checkModel($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
